// File: rtl/lcd_redraw_engine.sv
// Frame-buffer to parallel LCD redraw engine: fetches PIXELS words over a
// one-outstanding read port and strobes them out after a memory-write command.
module lcd_redraw_engine #(
   parameter int unsigned       DATA_W    = 16,
   parameter int unsigned       PIXELS    = 76800,
   parameter int unsigned       WR_CYCLES = 2,
   parameter int unsigned       TICK_DIV  = 50000,
   parameter logic [DATA_W-1:0] WRMEM_CMD = DATA_W'(16'h002C)
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic [DATA_W-1:0] ctrl_data_i,
   input  logic              ctrl_rd_i,
   input  logic              ctrl_wr_i,
   input  logic              ctrl_rs_i,
   input  logic [15:0]       fps_delay_i,
   input  logic              redraw_stb_i,
   input  logic              redraw_en_i,
   input  logic [31:0]       dma_addr_i,
   output logic              dma_busy_o,
   output logic [31:0]       mem_address_o,
   output logic              mem_read_o,
   input  logic              mem_waitrequest_i,
   input  logic [DATA_W-1:0] mem_readdata_i,
   input  logic              mem_readdatavalid_i,
   output logic [DATA_W-1:0] lcd_data_o,
   output logic              lcd_wr_n_o,
   output logic              lcd_rd_n_o,
   output logic              lcd_rs_o,
   output logic              lcd_cs_n_o
);

   localparam int unsigned IDX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
   localparam int unsigned PH_W  = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
   localparam int unsigned GAP_W = 16 + $clog2(TICK_DIV + 1);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIXELS - 1);
   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(WR_CYCLES - 1);
   localparam logic [GAP_W-1:0] TICKS    = GAP_W'(TICK_DIV);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CMD_LO  = 3'd1;
   localparam logic [2:0] S_CMD_HI  = 3'd2;
   localparam logic [2:0] S_RD_REQ  = 3'd3;
   localparam logic [2:0] S_RD_WAIT = 3'd4;
   localparam logic [2:0] S_PIX_LO  = 3'd5;
   localparam logic [2:0] S_PIX_HI  = 3'd6;

   logic [2:0]        state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [31:0]       base_q, base_d;
   logic              pend_q, pend_d;
   logic [GAP_W-1:0]  gap_q, gap_d;
   logic [DATA_W-1:0] lcd_data_q, lcd_data_d;
   logic              lcd_wr_n_q, lcd_wr_n_d;
   logic              lcd_rd_n_q, lcd_rd_n_d;
   logic              lcd_rs_q, lcd_rs_d;
   logic              lcd_cs_n_q, lcd_cs_n_d;
   logic              mem_read_q, mem_read_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic              busy_q, busy_d;
   logic              start_frame;
   logic              phase_done;

   always_comb begin
      state_d     = state_q;
      phase_d     = phase_q;
      idx_d       = idx_q;
      base_d      = base_q;
      pend_d      = pend_q;
      gap_d       = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
      start_frame = 1'b0;
      phase_done  = (phase_q == PH_LAST);

      case (state_q)
         S_IDLE: begin
            if (redraw_stb_i || pend_q || (redraw_en_i && gap_q == '0)) begin
               start_frame = 1'b1;
               state_d     = S_CMD_LO;
               base_d      = dma_addr_i & 32'hFFFF_FFFE;
               idx_d       = '0;
               phase_d     = '0;
            end
         end
         S_CMD_LO, S_CMD_HI, S_PIX_LO: begin
            if (phase_done) begin
               phase_d = '0;
               state_d = (state_q == S_CMD_LO) ? S_CMD_HI :
                         (state_q == S_CMD_HI) ? S_RD_REQ : S_PIX_HI;
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         S_RD_REQ: begin
            if (!mem_waitrequest_i) state_d = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            if (mem_readdatavalid_i) state_d = S_PIX_LO;
         end
         S_PIX_HI: begin
            if (phase_done) begin
               phase_d = '0;
               if (idx_q == IDX_LAST) begin
                  state_d = S_IDLE;
                  // Loading zero makes the very next IDLE cycle count as expired.
                  gap_d   = GAP_W'(fps_delay_i) * TICKS;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_RD_REQ;
               end
            end else begin
               phase_d = phase_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (start_frame) pend_d = 1'b0;
      else if (redraw_stb_i && busy_q) pend_d = 1'b1;
   end

   // Outputs are registered from the next state so the LCD pins never glitch.
   always_comb begin
      lcd_data_d = lcd_data_q;
      lcd_wr_n_d = 1'b1;
      lcd_rd_n_d = 1'b1;
      lcd_rs_d   = lcd_rs_q;
      lcd_cs_n_d = 1'b0;
      mem_read_d = (state_d == S_RD_REQ);
      mem_addr_d = mem_addr_q;
      busy_d     = (state_d != S_IDLE);

      if (state_q == S_IDLE && state_d == S_IDLE) begin
         lcd_data_d = ctrl_data_i;
         lcd_wr_n_d = ~ctrl_wr_i;
         lcd_rd_n_d = ~ctrl_rd_i;
         lcd_rs_d   = ctrl_rs_i;
      end else begin
         case (state_d)
            S_CMD_LO: begin
               lcd_data_d = WRMEM_CMD;
               lcd_rs_d   = 1'b0;
               lcd_wr_n_d = 1'b0;
            end
            S_CMD_HI: begin
               lcd_data_d = WRMEM_CMD;
               lcd_rs_d   = 1'b0;
            end
            S_RD_REQ: begin
               if (state_q != S_RD_REQ) mem_addr_d = base_q + (32'(idx_d) << 1);
            end
            S_PIX_LO: begin
               lcd_wr_n_d = 1'b0;
               if (state_q == S_RD_WAIT) begin
                  lcd_data_d = mem_readdata_i;
                  lcd_rs_d   = 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q    <= S_IDLE;
         phase_q    <= '0;
         idx_q      <= '0;
         base_q     <= '0;
         pend_q     <= 1'b0;
         gap_q      <= '0;
         lcd_data_q <= '0;
         lcd_wr_n_q <= 1'b1;
         lcd_rd_n_q <= 1'b1;
         lcd_rs_q   <= 1'b1;
         lcd_cs_n_q <= 1'b1;
         mem_read_q <= 1'b0;
         mem_addr_q <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         idx_q      <= idx_d;
         base_q     <= base_d;
         pend_q     <= pend_d;
         gap_q      <= gap_d;
         lcd_data_q <= lcd_data_d;
         lcd_wr_n_q <= lcd_wr_n_d;
         lcd_rd_n_q <= lcd_rd_n_d;
         lcd_rs_q   <= lcd_rs_d;
         lcd_cs_n_q <= lcd_cs_n_d;
         mem_read_q <= mem_read_d;
         mem_addr_q <= mem_addr_d;
         busy_q     <= busy_d;
      end
   end

   assign dma_busy_o    = busy_q;
   assign mem_address_o = mem_addr_q;
   assign mem_read_o    = mem_read_q;
   assign lcd_data_o    = lcd_data_q;
   assign lcd_wr_n_o    = lcd_wr_n_q;
   assign lcd_rd_n_o    = lcd_rd_n_q;
   assign lcd_rs_o      = lcd_rs_q;
   assign lcd_cs_n_o    = lcd_cs_n_q;

endmodule

// File: tb/tb_lcd_redraw_engine.sv
// Scoreboard bench for lcd_redraw_engine: expected LCD words and read
// addresses are queued when a frame is requested and popped as they appear.
module tb_lcd_redraw_engine;

   localparam int          DATA_W    = 16;
   localparam int          PIXELS    = 4;
   localparam int          WR_CYCLES = 1;
   localparam int          TICK_DIV  = 10;
   localparam logic [15:0] CMD       = 16'h002C;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic [15:0] ctrl_data_i = '0;
   logic        ctrl_rd_i = 1'b0;
   logic        ctrl_wr_i = 1'b0;
   logic        ctrl_rs_i = 1'b0;
   logic [15:0] fps_delay_i = '0;
   logic        redraw_stb_i = 1'b0;
   logic        redraw_en_i = 1'b0;
   logic [31:0] dma_addr_i = '0;
   logic        dma_busy_o;
   logic [31:0] mem_address_o;
   logic        mem_read_o;
   logic        mem_waitrequest_i = 1'b0;
   logic [15:0] mem_readdata_i = '0;
   logic        mem_readdatavalid_i = 1'b0;
   logic [15:0] lcd_data_o;
   logic        lcd_wr_n_o;
   logic        lcd_rd_n_o;
   logic        lcd_rs_o;
   logic        lcd_cs_n_o;

   always #5 clk_i = ~clk_i;

   lcd_redraw_engine #(
      .DATA_W(DATA_W), .PIXELS(PIXELS), .WR_CYCLES(WR_CYCLES),
      .TICK_DIV(TICK_DIV), .WRMEM_CMD(CMD)
   ) dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .ctrl_data_i(ctrl_data_i), .ctrl_rd_i(ctrl_rd_i), .ctrl_wr_i(ctrl_wr_i),
      .ctrl_rs_i(ctrl_rs_i), .fps_delay_i(fps_delay_i),
      .redraw_stb_i(redraw_stb_i), .redraw_en_i(redraw_en_i),
      .dma_addr_i(dma_addr_i), .dma_busy_o(dma_busy_o),
      .mem_address_o(mem_address_o), .mem_read_o(mem_read_o),
      .mem_waitrequest_i(mem_waitrequest_i), .mem_readdata_i(mem_readdata_i),
      .mem_readdatavalid_i(mem_readdatavalid_i),
      .lcd_data_o(lcd_data_o), .lcd_wr_n_o(lcd_wr_n_o), .lcd_rd_n_o(lcd_rd_n_o),
      .lcd_rs_o(lcd_rs_o), .lcd_cs_n_o(lcd_cs_n_o)
   );

   int          n_checks = 0;
   int          n_errors = 0;
   logic [16:0] exp_lcd[$];
   logic [31:0] exp_addr[$];
   logic        mon_en = 1'b1;
   logic        inject_rdv = 1'b0;
   int          wait_read = -1;
   int          read_num = 0;

   logic        prev_wr_n = 1'b1;
   logic [16:0] cur_strobe = '0;

   logic        m_in_req = 1'b0;
   logic        m_rsp_pend = 1'b0;
   logic [31:0] m_req_addr = '0;
   logic [15:0] m_rsp_data = '0;
   int          m_waits = 0;
   int          m_waits_init = 0;
   int          m_hold = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   // Frame-buffer contents: every word is a fixed function of its byte address.
   function automatic logic [15:0] pix_data(input logic [31:0] a);
      return a[15:0] ^ 16'hC3A5 ^ {a[31:28], 12'h000};
   endfunction

   task automatic push_frame(input logic [31:0] dma);
      logic [31:0] base;
      logic [31:0] a;
      base = dma & 32'hFFFF_FFFE;
      exp_lcd.push_back({1'b0, CMD});
      for (int i = 0; i < PIXELS; i++) begin
         a = base + 32'(2 * i);
         exp_addr.push_back(a);
         exp_lcd.push_back({1'b1, pix_data(a)});
      end
   endtask

   task automatic check_queues(input string tag);
      check_eq({tag, "_lcd_left"}, 32'(exp_lcd.size()), 32'd0);
      check_eq({tag, "_addr_left"}, 32'(exp_addr.size()), 32'd0);
      exp_lcd.delete();
      exp_addr.delete();
   endtask

   task automatic check_reset(input string tag);
      check_eq({tag, "_busy"}, 32'(dma_busy_o), 32'd0);
      check_eq({tag, "_mem_read"}, 32'(mem_read_o), 32'd0);
      check_eq({tag, "_mem_addr"}, mem_address_o, 32'd0);
      check_eq({tag, "_lcd_data"}, 32'(lcd_data_o), 32'd0);
      check_eq({tag, "_wr_n"}, 32'(lcd_wr_n_o), 32'd1);
      check_eq({tag, "_rd_n"}, 32'(lcd_rd_n_o), 32'd1);
      check_eq({tag, "_rs"}, 32'(lcd_rs_o), 32'd1);
      check_eq({tag, "_cs_n"}, 32'(lcd_cs_n_o), 32'd1);
   endtask

   task automatic wait_busy(input logic lvl, input int limit, input string tag, output int cycles);
      cycles = 0;
      while (dma_busy_o !== lvl && cycles < limit) begin
         @(negedge clk_i);
         cycles++;
      end
      check_eq(tag, 32'(dma_busy_o), 32'(lvl));
   endtask

   task automatic pulse_stb(input string tag);
      redraw_stb_i = 1'b1;
      @(negedge clk_i);
      redraw_stb_i = 1'b0;
      check_eq({tag, "_busy_rise"}, 32'(dma_busy_o), 32'd1);
   endtask

   task automatic count_busy(input int n, output int hits);
      hits = 0;
      repeat (n) begin
         @(negedge clk_i);
         if (dma_busy_o) hits++;
      end
   endtask

   // LCD monitor: each falling wr_n during a frame pops one expected word,
   // and the word must still be on the bus when wr_n rises again.
   initial begin
      forever begin
         @(negedge clk_i);
         if (mon_en && rst_n_i && dma_busy_o) begin
            if (prev_wr_n && !lcd_wr_n_o) begin
               check_eq("lcd_strobe_expected", 32'(exp_lcd.size() != 0), 32'd1);
               if (exp_lcd.size() != 0) begin
                  cur_strobe = exp_lcd.pop_front();
                  check_eq("lcd_word", 32'({lcd_rs_o, lcd_data_o}), 32'(cur_strobe));
                  check_eq("lcd_rd_cs", 32'({lcd_rd_n_o, lcd_cs_n_o}), 32'd2);
               end
            end else if (!prev_wr_n && lcd_wr_n_o) begin
               check_eq("lcd_word_held", 32'({lcd_rs_o, lcd_data_o}), 32'(cur_strobe));
            end
         end
         prev_wr_n = lcd_wr_n_o;
      end
   end

   // Memory slave: optional wait-states on one chosen read, data one cycle after accept.
   initial begin
      forever begin
         @(negedge clk_i);
         mem_readdatavalid_i = 1'b0;
         if (!rst_n_i) begin
            m_in_req          = 1'b0;
            m_rsp_pend        = 1'b0;
            mem_waitrequest_i = 1'b0;
         end else begin
            if (m_rsp_pend) begin
               mem_readdatavalid_i = 1'b1;
               mem_readdata_i      = m_rsp_data;
               m_rsp_pend          = 1'b0;
            end else if (inject_rdv) begin
               mem_readdatavalid_i = 1'b1;
               mem_readdata_i      = 16'hDEAD;
               inject_rdv          = 1'b0;
            end
            if (mem_read_o) begin
               if (!m_in_req) begin
                  m_in_req     = 1'b1;
                  m_req_addr   = mem_address_o;
                  m_hold       = 1;
                  m_waits      = (read_num == wait_read) ? 3 : 0;
                  m_waits_init = m_waits;
               end else begin
                  m_hold++;
                  if (mon_en) check_eq("rd_addr_stable", mem_address_o, m_req_addr);
               end
               if (m_waits > 0) begin
                  mem_waitrequest_i = 1'b1;
                  m_waits--;
               end else begin
                  mem_waitrequest_i = 1'b0;
                  if (mon_en) begin
                     check_eq("rd_expected", 32'(exp_addr.size() != 0), 32'd1);
                     if (exp_addr.size() != 0) check_eq("rd_addr", mem_address_o, exp_addr.pop_front());
                     check_eq("rd_hold_cycles", 32'(m_hold), 32'(m_waits_init + 1));
                  end
                  m_rsp_pend = 1'b1;
                  m_rsp_data = pix_data(mem_address_o);
                  m_in_req   = 1'b0;
                  read_num++;
               end
            end else begin
               mem_waitrequest_i = 1'b0;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hits;
      int lows;

      repeat (3) @(negedge clk_i);
      check_reset("rst");
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Direct CPU access while idle
      ctrl_wr_i = 1'b1; ctrl_data_i = 16'hABCD; ctrl_rs_i = 1'b0;
      @(negedge clk_i);
      check_eq("ctrl_wr_n", 32'(lcd_wr_n_o), 32'd0);
      check_eq("ctrl_data", 32'(lcd_data_o), 32'hABCD);
      check_eq("ctrl_rs", 32'(lcd_rs_o), 32'd0);
      check_eq("ctrl_cs_n", 32'(lcd_cs_n_o), 32'd0);
      check_eq("ctrl_rd_n_idle", 32'(lcd_rd_n_o), 32'd1);
      ctrl_wr_i = 1'b0; ctrl_rd_i = 1'b1; ctrl_rs_i = 1'b1; ctrl_data_i = 16'h1234;
      @(negedge clk_i);
      check_eq("ctrl_rd_n", 32'(lcd_rd_n_o), 32'd0);
      check_eq("ctrl_wr_n_hi", 32'(lcd_wr_n_o), 32'd1);
      check_eq("ctrl_rs_hi", 32'(lcd_rs_o), 32'd1);
      check_eq("ctrl_data2", 32'(lcd_data_o), 32'h1234);
      ctrl_rd_i = 1'b0; ctrl_data_i = '0;
      @(negedge clk_i);

      // Plain frame; CPU strobes held active throughout must be ignored
      dma_addr_i = 32'h0000_1000;
      push_frame(dma_addr_i);
      pulse_stb("f1");
      ctrl_wr_i = 1'b1; ctrl_rd_i = 1'b1; ctrl_data_i = 16'hFFFF; ctrl_rs_i = 1'b0;
      wait_busy(1'b0, 200, "f1_end", n);
      ctrl_wr_i = 1'b0; ctrl_rd_i = 1'b0; ctrl_data_i = '0;
      check_queues("f1");
      repeat (2) @(negedge clk_i);

      // Three wait-states on the second read of the frame
      wait_read = read_num + 1;
      push_frame(dma_addr_i);
      pulse_stb("f2");
      wait_busy(1'b0, 200, "f2_end", n);
      wait_read = -1;
      check_queues("f2");

      // Odd base near the top of the address space: LSB dropped, addresses wrap
      dma_addr_i = 32'hFFFF_FFFD;
      push_frame(dma_addr_i);
      pulse_stb("f3");
      wait_busy(1'b0, 200, "f3_end", n);
      check_queues("f3");

      // Two strobes mid-frame queue exactly one more frame
      dma_addr_i = 32'h0000_2003;
      push_frame(dma_addr_i);
      pulse_stb("f4");
      repeat (4) @(negedge clk_i);
      push_frame(dma_addr_i);
      redraw_stb_i = 1'b1; @(negedge clk_i); redraw_stb_i = 1'b0;
      repeat (3) @(negedge clk_i);
      redraw_stb_i = 1'b1; @(negedge clk_i); redraw_stb_i = 1'b0;
      wait_busy(1'b0, 200, "f4_end", n);
      wait_busy(1'b1, 10, "f5_start", n);
      check_eq("pending_idle_cycles", 32'(n), 32'd1);
      wait_busy(1'b0, 200, "f5_end", n);
      count_busy(40, hits);
      check_eq("no_third_frame", 32'(hits), 32'd0);
      check_queues("f4f5");

      // Auto-redraw: gap is fps_delay*TICK_DIV clocks beyond the single IDLE cycle
      dma_addr_i = 32'h0000_3000;
      fps_delay_i = 16'd2;
      push_frame(dma_addr_i);
      redraw_en_i = 1'b1;
      pulse_stb("a1");
      wait_busy(1'b0, 200, "a1_end", n);
      push_frame(dma_addr_i);
      wait_busy(1'b1, 100, "a2_start", n);
      check_eq("gap_fps2", 32'(n), 32'(2 * TICK_DIV + 1));
      fps_delay_i = 16'd0;
      wait_busy(1'b0, 200, "a2_end", n);
      // Strobe lands on the same IDLE cycle as timer expiry: still only one frame
      push_frame(dma_addr_i);
      pulse_stb("a3");
      redraw_en_i = 1'b0;
      wait_busy(1'b0, 200, "a3_end", n);
      count_busy(40, hits);
      check_eq("auto_stopped", 32'(hits), 32'd0);
      check_queues("auto");

      // Reset during a pixel strobe, followed by a stale readdatavalid
      mon_en = 1'b0;
      dma_addr_i = 32'h0000_4000;
      pulse_stb("r1");
      n = 0;
      while (!(lcd_wr_n_o == 1'b0 && lcd_rs_o == 1'b1) && n < 100) begin
         @(negedge clk_i);
         n++;
      end
      check_eq("reach_pix_lo", 32'({lcd_wr_n_o, lcd_rs_o}), 32'd1);
      rst_n_i = 1'b0;
      @(negedge clk_i);
      check_reset("rst_mid");
      rst_n_i = 1'b1;
      inject_rdv = 1'b1;
      lows = 0;
      hits = 0;
      repeat (10) begin
         @(negedge clk_i);
         if (!lcd_wr_n_o) lows++;
         if (dma_busy_o) hits++;
      end
      check_eq("rst_no_strobe", 32'(lows), 32'd0);
      check_eq("rst_no_busy", 32'(hits), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
